// File: rtl/hub_pkg.sv
// hub_pkg: shared widths, phase encoding and request record for the hub arbiter.
package hub_pkg;
  localparam int HUB_ADDR_W = 14;
  localparam int HUB_DATA_W = 32;
  localparam int HUB_WB_W   = 4;
  typedef enum logic {PH_SETUP = 1'b0, PH_BUS = 1'b1} hub_phase_t;
  typedef struct packed {
    logic                  w;
    logic [HUB_WB_W-1:0]   wb;
    logic [HUB_ADDR_W-1:0] a;
    logic [HUB_DATA_W-1:0] d;
  } hub_req_t;
endpackage

// File: rtl/hub_rr_pick.sv
// hub_rr_pick: combinational round-robin finder of the first set request at or after i_start.
module hub_rr_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_start,
  output logic         o_found,
  output logic [W-1:0] o_idx
);
  always_comb begin
    o_found = 1'b0;
    o_idx   = i_start;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[i_start + W'(k)]) begin
        o_found = 1'b1;
        o_idx   = i_start + W'(k);
      end
    end
  end
endmodule

// File: rtl/hub_arbiter.sv
// hub_arbiter: two-cycle (setup/bus) slot scheduler sharing hub_mem among COGS requesters.
// Define HUB_SLOT_SKIP_EN for work-conserving mode (idle slots handed to the next pending cog).
module hub_arbiter
  import hub_pkg::*;
#(
  parameter int COGS   = 8,
  parameter int SLOT_W = 3
) (
  input  logic                       clk_cog,
  input  logic                       res,
  input  logic [COGS-1:0]            req,
  input  logic [COGS-1:0]            req_w,
  input  logic [HUB_WB_W*COGS-1:0]   req_wb,
  input  logic [HUB_ADDR_W*COGS-1:0] req_a,
  input  logic [HUB_DATA_W*COGS-1:0] req_d,
  output logic [COGS-1:0]            ack,
  output logic [HUB_DATA_W-1:0]      q,
  output logic [SLOT_W-1:0]          slot,
  output logic                       mem_ena_bus,
  output logic                       mem_w,
  output logic [HUB_WB_W-1:0]        mem_wb,
  output logic [HUB_ADDR_W-1:0]      mem_a,
  output logic [HUB_DATA_W-1:0]      mem_d,
  input  logic [HUB_DATA_W-1:0]      mem_q
);
  hub_phase_t        r_phase;
  logic [SLOT_W-1:0] r_slot, r_grant_cog, r_pend_cog, w_gidx;
  logic              r_grant, r_pend, r_ena, w_gnt;
  hub_req_t          r_req, w_sel;
`ifdef HUB_SLOT_SKIP_EN
  logic              w_found;
  logic [SLOT_W-1:0] w_pick;
  // The cog being acked this cycle is excluded so it waits for a later turn.
  hub_rr_pick #(.N(COGS), .W(SLOT_W)) u_pick (
    .i_req  (req & ~ack),
    .i_start(r_slot + SLOT_W'(1)),
    .o_found(w_found),
    .o_idx  (w_pick)
  );
  assign w_gnt  = req[r_slot] | w_found;
  assign w_gidx = (req[r_slot] | ~w_found) ? r_slot : w_pick;
`else
  assign w_gnt  = req[r_slot];
  assign w_gidx = r_slot;
`endif
  assign w_sel = {req_w[w_gidx],
                  req_wb[HUB_WB_W*w_gidx +: HUB_WB_W],
                  req_a[HUB_ADDR_W*w_gidx +: HUB_ADDR_W],
                  req_d[HUB_DATA_W*w_gidx +: HUB_DATA_W]};
  always_comb begin
    ack             = '0;
    ack[r_pend_cog] = r_pend;
  end
  assign q           = mem_q;
  assign slot        = r_slot;
  assign mem_ena_bus = r_ena;
  assign mem_w       = r_req.w;
  assign mem_wb      = r_req.wb;
  assign mem_a       = r_req.a;
  assign mem_d       = r_req.d;
  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      r_phase     <= PH_SETUP;
      r_slot      <= '0;
      r_ena       <= 1'b0;
      r_req       <= '0;
      r_grant     <= 1'b0;
      r_grant_cog <= '0;
      r_pend      <= 1'b0;
      r_pend_cog  <= '0;
    end else if (r_phase == PH_SETUP) begin
      r_phase     <= PH_BUS;
      r_ena       <= 1'b1;
      r_slot      <= w_gidx;
      r_grant     <= w_gnt;
      r_grant_cog <= w_gidx;
      r_pend      <= 1'b0;
      if (w_gnt) r_req <= w_sel;
      else begin
        r_req.w  <= 1'b0;
        r_req.wb <= '0;
      end
    end else begin
      r_phase    <= PH_SETUP;
      r_ena      <= 1'b0;
      r_slot     <= r_slot + SLOT_W'(1);
      r_pend     <= r_grant;
      r_pend_cog <= r_grant_cog;
      r_req.w    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_hub_arbiter.sv
// tb_hub_arbiter: scoreboard bench for hub_arbiter with a behavioural hub_mem.
module tb_hub_arbiter;
  localparam int COGS = 8;
  typedef struct {int cog; logic [31:0] q; bit rd; int cyc;} exp_t;
  logic clk_cog = 1'b0, res = 1'b1;
  logic [COGS-1:0] req = '0, req_w = '0, ack;
  logic [4*COGS-1:0] req_wb = '0;
  logic [14*COGS-1:0] req_a = '0;
  logic [32*COGS-1:0] req_d = '0;
  logic [31:0] q, mem_d, mem_q;
  logic [2:0] slot;
  logic mem_ena_bus, mem_w;
  logic [3:0] mem_wb;
  logic [13:0] mem_a;
  logic [31:0] mem [0:16383];
  exp_t sbq[$];
  int n_chk = 0, n_err = 0, rc = 0, w_cnt = 0, last6 = -1;

  hub_arbiter #(.COGS(COGS), .SLOT_W(3)) dut (
    .clk_cog(clk_cog), .res(res), .req(req), .req_w(req_w), .req_wb(req_wb),
    .req_a(req_a), .req_d(req_d), .ack(ack), .q(q), .slot(slot),
    .mem_ena_bus(mem_ena_bus), .mem_w(mem_w), .mem_wb(mem_wb), .mem_a(mem_a),
    .mem_d(mem_d), .mem_q(mem_q)
  );

  always #5 clk_cog = ~clk_cog;

  always @(posedge clk_cog) begin
    if (mem_ena_bus) begin
      if (mem_w)
        for (int b = 0; b < 4; b++) if (mem_wb[b]) mem[mem_a][8*b +: 8] <= mem_d[8*b +: 8];
      mem_q <= mem[mem_a];
    end
  end

  always @(posedge clk_cog) rc <= res ? 0 : rc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic int exp_ack(input int r, input int c);
    int g = r + (r % 2);
    while (((g / 2) % COGS) != c) g += 2;
    return g + 2;
  endfunction

  always @(negedge clk_cog) begin
    if (mem_w) w_cnt++;
    if (!res && ack != '0) begin
      int c;
      int hit;
      c = 0;
      hit = -1;
      for (int b = 0; b < COGS; b++) if (ack[b]) c = b;
      chk("ack_onehot", $countones(ack), 1);
      for (int i = 0; i < sbq.size(); i++) if (hit < 0 && sbq[i].cog == c) hit = i;
      if (hit < 0) chk("unexp_ack", {24'b0, ack}, 0);
      else begin
`ifndef HUB_SLOT_SKIP_EN
        chk("ack_cyc", rc, sbq[hit].cyc);
`endif
        if (sbq[hit].rd) chk("ack_q", q, sbq[hit].q);
        sbq.delete(hit);
      end
`ifdef HUB_SLOT_SKIP_EN
      if (c == 6 && last6 >= 0) chk("skip_gap", {31'b0, (rc - last6 >= 2) && (rc - last6 <= 4)}, 1);
`endif
      if (c == 6) last6 = rc;
    end
  end

  task automatic sync_slot(input int s);
    int n = 0;
    @(negedge clk_cog);
    while (!((rc % 2 == 0) && ((rc / 2) % COGS == s)) && n < 40) begin
      @(negedge clk_cog);
      n++;
    end
  endtask

  // Caller is at a negedge; req stays high across reps and drops after the last ack.
  task automatic do_req(input int c, input bit w, input logic [3:0] wb, input logic [13:0] a,
                        input logic [31:0] d, input logic [31:0] eq, input int reps);
    int n;
    req_w[c] = w;
    req_wb[4*c +: 4] = wb;
    req_a[14*c +: 14] = a;
    req_d[32*c +: 32] = d;
    req[c] = 1'b1;
    for (int r = 0; r < reps; r++) begin
      sbq.push_back('{cog: c, q: eq, rd: !w, cyc: exp_ack(rc, c)});
      n = 0;
      do begin
        @(negedge clk_cog);
        n++;
      end while (!ack[c] && n < 40);
      chk($sformatf("ack_seen_c%0d", c), {31'b0, ack[c]}, 1);
    end
    @(posedge clk_cog);
    #1 req[c] = 1'b0;
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    mem[16] = 32'hDEADBEEF;
    for (int c = 0; c < COGS; c++) mem[256 + c] = 32'hA5A50000 + c;
    repeat (3) @(posedge clk_cog);
    @(negedge clk_cog);
    chk("rst_slot", {29'b0, slot}, 0);
    chk("rst_ack", {24'b0, ack}, 0);
    chk("rst_ena", {31'b0, mem_ena_bus}, 0);
    chk("rst_memctl", {mem_w, mem_wb, mem_a}, 0);
    chk("rst_d", mem_d, 0);
    res = 1'b0;
    repeat (32) begin
      chk("idle_ena", {31'b0, mem_ena_bus}, rc % 2);
      chk("idle_slot", {29'b0, slot}, (rc / 2) % COGS);
      chk("idle_w", {31'b0, mem_w}, 0);
      @(negedge clk_cog);
    end
    sync_slot(0);
    do_req(3, 1'b0, 4'h0, 14'h0010, 32'h0, 32'hDEADBEEF, 1);
    repeat (20) @(negedge clk_cog);
    chk("one_ack", sbq.size(), 0);
    @(negedge clk_cog);
    w0 = w_cnt;
    do_req(5, 1'b1, 4'b0101, 14'h0020, 32'h11223344, 32'h0, 1);
    repeat (4) @(negedge clk_cog);
    chk("w_once", w_cnt - w0, 1);
    do_req(5, 1'b0, 4'h0, 14'h0020, 32'h0, 32'h00220044, 1);
    sync_slot(0);
    for (int c = 0; c < COGS; c++) begin
      automatic int k = c;
      fork
        do_req(k, 1'b0, 4'h0, 14'h0100 + 14'(k), 32'h0, 32'hA5A50000 + k, (k == 0) ? 2 : 1);
      join_none
    end
    wait fork;
    sync_slot(2);
    w0 = w_cnt;
    req_w[2] = 1'b1;
    req_wb[8 +: 4] = 4'hF;
    req_a[28 +: 14] = 14'h0030;
    req_d[64 +: 32] = 32'hCAFEF00D;
    req[2] = 1'b1;
    @(posedge clk_cog);
    #1;
    chk("rst_w_live", {31'b0, mem_w}, 1);
    res = 1'b1;
    #1;
    chk("rst_w_kill", {31'b0, mem_w}, 0);
    req[2] = 1'b0;
    repeat (2) @(negedge clk_cog);
    res = 1'b0;
    chk("rel_slot", {29'b0, slot}, 0);
    chk("rel_phase", {31'b0, mem_ena_bus}, 0);
    repeat (20) @(negedge clk_cog);
    chk("rst_mem", mem[48], 0);
    last6 = -1;
    @(negedge clk_cog);
    do_req(6, 1'b0, 4'h0, 14'h0010, 32'h0, 32'hDEADBEEF, 3);
    repeat (20) @(negedge clk_cog);
    chk("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
